// File: rtl/conv3x3_mc_pipe_pkg.sv
// conv_pkg: shared constants and helpers for the multi-channel 3x3 convolution engine.
//   - mode encodings for i_mode
//   - preset kernels (K1..K9, row-major, K5 is the centre tap)
//   - aw_calc: signed accumulator width derived from sample/coefficient widths
//   - clamp_u: saturate a signed value into an unsigned dw-bit range
package conv_pkg;

   localparam logic [1:0] ModeSharpen  = 2'd0;
   localparam logic [1:0] ModeStrong   = 2'd1;
   localparam logic [1:0] ModeIdentity = 2'd2;
   localparam logic [1:0] ModeCustom   = 2'd3;

   localparam int KernSharpen  [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
   localparam int KernStrong   [9] = '{-1, -1, -1, -1, 9, -1, -1, -1, -1};
   localparam int KernIdentity [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

   // Nine DW x KW products plus a bias never exceed this width.
   function automatic int unsigned aw_calc(input int unsigned dw, input int unsigned kw);
      return dw + kw + 5;
   endfunction

   function automatic logic [31:0] clamp_u(input logic signed [63:0] v, input int unsigned dw);
      logic signed [63:0] hi;
      hi = (64'sd1 <<< dw) - 64'sd1;
      if (v < 64'sd0) begin
         return 32'd0;
      end else if (v > hi) begin
         return hi[31:0];
      end else begin
         return v[31:0];
      end
   endfunction

endpackage

// File: rtl/conv3x3_mc_pipe_if.sv
// conv3x3_mc_pipe_if: stream interface of the convolution engine.
//   Input side : i_valid/o_ready handshake, i_sof, i_win (9 pixels, p1 in LSBs),
//                config inputs i_mode, i_kern, i_shift, i_bias.
//   Output side: o_valid/i_ready handshake, o_pix, o_sof.
//   slave  modport: the engine.  master modport: the stream source/sink.
interface conv3x3_mc_pipe_if #(
   parameter int unsigned CH = 3,
   parameter int unsigned DW = 8,
   parameter int unsigned KW = 8,
   parameter int unsigned SW = 4
) ();
   import conv_pkg::*;

   localparam int unsigned AW = aw_calc(DW, KW);

   logic                 i_valid;
   logic                 o_ready;
   logic                 i_sof;
   logic [9*CH*DW-1:0]   i_win;
   logic [1:0]           i_mode;
   logic [9*KW-1:0]      i_kern;
   logic [SW-1:0]        i_shift;
   logic signed [AW-1:0] i_bias;
   logic                 o_valid;
   logic                 i_ready;
   logic [CH*DW-1:0]     o_pix;
   logic                 o_sof;

   modport slave (
      input  i_valid, i_sof, i_win, i_mode, i_kern, i_shift, i_bias, i_ready,
      output o_ready, o_valid, o_pix, o_sof
   );

   modport master (
      output i_valid, i_sof, i_win, i_mode, i_kern, i_shift, i_bias, i_ready,
      input  o_ready, o_valid, o_pix, o_sof
   );

endinterface

// File: rtl/conv3x3_mac_lane.sv
// conv3x3_mac_lane: one colour channel of the 3-stage 3x3 MAC datapath.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   en_i    : pipeline advance; all stage registers hold when low
//   vld_i   : stage-2 beat is valid; output register only loads real results
//   win_i   : nine DW-bit samples of this channel, p1 in LSBs
//   kern_i  : nine KW-bit signed coefficients, K1 in LSBs (stage-1 config)
//   shift_i : rounding right shift for the beat in stage 2
//   bias_i  : signed bias for the beat in stage 2
//   pix_o   : clamped registered result
module conv3x3_mac_lane #(
   parameter int unsigned DW = 8,
   parameter int unsigned KW = 8,
   parameter int unsigned SW = 4,
   parameter int unsigned AW = 21
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 vld_i,
   input  logic [9*DW-1:0]      win_i,
   input  logic [9*KW-1:0]      kern_i,
   input  logic [SW-1:0]        shift_i,
   input  logic signed [AW-1:0] bias_i,
   output logic [DW-1:0]        pix_o
);
   import conv_pkg::*;

   logic signed [AW-1:0] samp_ext [9];
   logic signed [AW-1:0] kern_ext [9];
   logic signed [AW-1:0] prod_d   [9];
   logic signed [AW-1:0] prod_q   [9];
   logic signed [AW-1:0] row_d    [3];
   logic signed [AW-1:0] row_q    [3];
   logic signed [AW-1:0] sum;
   logic signed [AW-1:0] rnd;
   logic signed [AW-1:0] shifted;
   logic signed [63:0]   wide;
   logic [DW-1:0]        pix_d;
   logic [DW-1:0]        pix_q;

   // Stage 1: samples are unsigned, so zero-extend; coefficients sign-extend.
   always_comb begin
      for (int j = 0; j < 9; j++) begin
         samp_ext[j] = {{(AW-DW){1'b0}}, win_i[j*DW +: DW]};
         kern_ext[j] = {{(AW-KW){kern_i[j*KW+KW-1]}}, kern_i[j*KW +: KW]};
         prod_d[j]   = samp_ext[j] * kern_ext[j];
      end
   end

   // Stage 2: one sum per window row.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         row_d[r] = prod_q[3*r] + prod_q[3*r+1] + prod_q[3*r+2];
      end
   end

   // Stage 3: bias, round half up, arithmetic shift, clamp.
   always_comb begin
      sum = row_q[0] + row_q[1] + row_q[2] + bias_i;
      rnd = '0;
      if (shift_i != '0) begin
         rnd = AW'(1) <<< (shift_i - SW'(1));
      end
      shifted = (sum + rnd) >>> shift_i;
      wide    = {{(64-AW){shifted[AW-1]}}, shifted};
      pix_d   = DW'(clamp_u(wide, DW));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int j = 0; j < 9; j++) prod_q[j] <= '0;
         for (int r = 0; r < 3; r++) row_q[r] <= '0;
         pix_q <= '0;
      end else if (en_i) begin
         for (int j = 0; j < 9; j++) prod_q[j] <= prod_d[j];
         for (int r = 0; r < 3; r++) row_q[r] <= row_d[r];
         if (vld_i) begin
            pix_q <= pix_d;
         end
      end
   end

   assign pix_o = pix_q;

endmodule

// File: rtl/conv3x3_mc_pipe.sv
// conv3x3_mc_pipe: multi-channel 3x3 convolution engine, 3-stage pipeline with
// valid/ready backpressure and frame-atomic kernel/shift/bias configuration.
//   iClk : clock
//   iRst : synchronous active-high reset
//   bus  : stream interface (slave modport), see conv3x3_mc_pipe_if
module conv3x3_mc_pipe #(
   parameter int unsigned CH = 3,
   parameter int unsigned DW = 8,
   parameter int unsigned KW = 8,
   parameter int unsigned SW = 4
) (
   input logic              iClk,
   input logic              iRst,
   conv3x3_mc_pipe_if.slave bus
);
   import conv_pkg::*;

   localparam int unsigned AW = aw_calc(DW, KW);

   logic                 adv;
   logic                 accept;
   logic                 load;

   logic [9*KW-1:0]      kern_ident;
   logic [9*KW-1:0]      kern_sel;
   logic [9*KW-1:0]      eff_kern;
   logic [SW-1:0]        eff_shift;
   logic signed [AW-1:0] eff_bias;

   logic [9*KW-1:0]      cfg_kern_q;
   logic [SW-1:0]        cfg_shift_q;
   logic signed [AW-1:0] cfg_bias_q;

   logic                 s1_valid_q, s2_valid_q, out_valid_q;
   logic                 s1_sof_q, s2_sof_q, out_sof_q;
   logic [SW-1:0]        s1_shift_q, s2_shift_q;
   logic signed [AW-1:0] s1_bias_q, s2_bias_q;

   logic [DW-1:0]        lane_pix [CH];

   // Every stage moves together; a full output register with no taker stalls all.
   assign adv         = ~out_valid_q | bus.i_ready;
   assign bus.o_ready = adv & ~iRst;
   assign accept      = bus.i_valid & bus.o_ready;
   assign load        = accept & bus.i_sof;

   always_comb begin
      kern_ident = '0;
      kern_sel   = '0;
      for (int j = 0; j < 9; j++) begin
         kern_ident[j*KW +: KW] = KW'(KernIdentity[j]);
         case (bus.i_mode)
            ModeSharpen:  kern_sel[j*KW +: KW] = KW'(KernSharpen[j]);
            ModeStrong:   kern_sel[j*KW +: KW] = KW'(KernStrong[j]);
            ModeIdentity: kern_sel[j*KW +: KW] = KW'(KernIdentity[j]);
            default:      kern_sel[j*KW +: KW] = bus.i_kern[j*KW +: KW];
         endcase
      end
   end

   // The SOF beat already uses the config it loads.
   always_comb begin
      eff_kern  = load ? kern_sel    : cfg_kern_q;
      eff_shift = load ? bus.i_shift : cfg_shift_q;
      eff_bias  = load ? bus.i_bias  : cfg_bias_q;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         cfg_kern_q  <= kern_ident;
         cfg_shift_q <= '0;
         cfg_bias_q  <= '0;
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         s1_sof_q    <= 1'b0;
         s2_sof_q    <= 1'b0;
         out_sof_q   <= 1'b0;
         s1_shift_q  <= '0;
         s2_shift_q  <= '0;
         s1_bias_q   <= '0;
         s2_bias_q   <= '0;
      end else begin
         if (load) begin
            cfg_kern_q  <= kern_sel;
            cfg_shift_q <= bus.i_shift;
            cfg_bias_q  <= bus.i_bias;
         end
         if (adv) begin
            s1_valid_q  <= accept;
            s1_sof_q    <= load;
            s1_shift_q  <= eff_shift;
            s1_bias_q   <= eff_bias;
            s2_valid_q  <= s1_valid_q;
            s2_sof_q    <= s1_sof_q;
            s2_shift_q  <= s1_shift_q;
            s2_bias_q   <= s1_bias_q;
            out_valid_q <= s2_valid_q;
            out_sof_q   <= s2_sof_q;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_lane
      logic [9*DW-1:0] lane_win;

      always_comb begin
         lane_win = '0;
         for (int j = 0; j < 9; j++) begin
            lane_win[j*DW +: DW] = bus.i_win[(j*CH + c)*DW +: DW];
         end
      end

      conv3x3_mac_lane #(
         .DW (DW),
         .KW (KW),
         .SW (SW),
         .AW (AW)
      ) u_lane (
         .clk_i   (iClk),
         .rst_i   (iRst),
         .en_i    (adv),
         .vld_i   (s2_valid_q),
         .win_i   (lane_win),
         .kern_i  (eff_kern),
         .shift_i (s2_shift_q),
         .bias_i  (s2_bias_q),
         .pix_o   (lane_pix[c])
      );
   end

   always_comb begin
      bus.o_pix = '0;
      for (int c = 0; c < CH; c++) begin
         bus.o_pix[c*DW +: DW] = lane_pix[c];
      end
   end

   assign bus.o_valid = out_valid_q;
   assign bus.o_sof   = out_sof_q;

endmodule

// File: tb/tb_conv3x3_mc_pipe.sv
// tb_conv3x3_mc_pipe: directed self-checking bench for conv3x3_mc_pipe (CH=3, DW=8, KW=8, SW=4).
module tb_conv3x3_mc_pipe;
   import conv_pkg::*;

   localparam int unsigned CH = 3;
   localparam int unsigned DW = 8;
   localparam int unsigned KW = 8;
   localparam int unsigned SW = 4;
   localparam int unsigned AW = DW + KW + 5;

   localparam logic [23:0] AtExp   [4] = '{24'h323232, 24'h323232, 24'hD2D2D2, 24'hD2D2D2};
   localparam logic [1:0]  AtMode  [4] = '{2'd2, 2'd0, 2'd0, 2'd2};
   localparam bit          AtSof   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   localparam int          AtShift [4] = '{0, 3, 0, 4};
   localparam int          AtBias  [4] = '{0, 50, 0, 100};

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   int   sent;
   int   rcv;
   bit   acc;
   bit   pop;
   logic [9*CH*DW-1:0] at_win;

   conv3x3_mc_pipe_if #(.CH(CH), .DW(DW), .KW(KW), .SW(SW)) bus ();

   conv3x3_mc_pipe #(.CH(CH), .DW(DW), .KW(KW), .SW(SW)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // All neighbours nb (optionally varied per position), centre p5 = ctr.
   function automatic logic [9*CH*DW-1:0] mkwin(input logic [23:0] nb, input logic [23:0] ctr,
                                                 input bit vary);
      logic [9*CH*DW-1:0] w;
      w = '0;
      for (int j = 0; j < 9; j++) begin
         if (j == 4) w[j*24 +: 24] = ctr;
         else if (vary) w[j*24 +: 24] = nb ^ (24'(j) * 24'h0F1E2D);
         else w[j*24 +: 24] = nb;
      end
      return w;
   endfunction

   function automatic logic [23:0] bp_ctr(input int i);
      return {8'(i * 3 + 1), 8'(i * 5 + 2), 8'(i * 7 + 3)};
   endfunction

   task automatic drive(input logic [9*CH*DW-1:0] w, input logic [1:0] mode,
                        input logic [9*KW-1:0] kern, input logic [SW-1:0] sh,
                        input logic signed [AW-1:0] bias, input bit sof);
      bus.i_valid = 1'b1;
      bus.i_win   = w;
      bus.i_mode  = mode;
      bus.i_kern  = kern;
      bus.i_shift = sh;
      bus.i_bias  = bias;
      bus.i_sof   = sof;
   endtask

   // One beat through an empty pipe: latency, value and SOF alignment.
   task automatic single(input string tag, input logic [9*CH*DW-1:0] w, input logic [1:0] mode,
                         input logic [9*KW-1:0] kern, input logic [SW-1:0] sh,
                         input logic signed [AW-1:0] bias, input bit sof, input logic [23:0] exp);
      drive(w, mode, kern, sh, bias, sof);
      #1;
      chk1({tag, "_ordy"}, bus.o_ready, 1'b1);
      tick();
      bus.i_valid = 1'b0;
      bus.i_sof   = 1'b0;
      chk1({tag, "_lat1"}, bus.o_valid, 1'b0);
      tick();
      chk1({tag, "_lat2"}, bus.o_valid, 1'b0);
      tick();
      chk1({tag, "_vld"}, bus.o_valid, 1'b1);
      chk24({tag, "_pix"}, bus.o_pix, exp);
      chk1({tag, "_sof"}, bus.o_sof, sof);
      tick();
      chk1({tag, "_drain"}, bus.o_valid, 1'b0);
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      rst         = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_sof   = 1'b0;
      bus.i_win   = '0;
      bus.i_mode  = ModeIdentity;
      bus.i_kern  = '0;
      bus.i_shift = '0;
      bus.i_bias  = '0;
      bus.i_ready = 1'b1;
      at_win      = mkwin(24'h0A0A0A, 24'h323232, 1'b0);

      // Reset state
      tick();
      tick();
      chk1("rst_ordy", bus.o_ready, 1'b0);
      chk1("rst_vld", bus.o_valid, 1'b0);
      chk24("rst_pix", bus.o_pix, 24'h0);
      chk1("rst_sof", bus.o_sof, 1'b0);
      rst = 1'b0;
      #1;
      chk1("rel_ordy", bus.o_ready, 1'b1);

      // Presets and clamps
      single("ident", mkwin(24'hA53C7E, 24'h123456, 1'b1), ModeIdentity, '0, '0, '0, 1'b1,
             24'h123456);
      single("sharp_flat", mkwin(24'h646464, 24'h646464, 1'b0), ModeSharpen, '0, '0, '0, 1'b1,
             24'h646464);
      single("strong_hi", mkwin(24'h000000, 24'hFFFFFF, 1'b0), ModeStrong, '0, '0, '0, 1'b1,
             24'hFFFFFF);
      single("strong_lo", mkwin(24'hFFFFFF, 24'h000000, 1'b0), ModeStrong, '0, '0, '0, 1'b1,
             24'h000000);

      // Custom kernels: rounding shift, bias, sign extension of coefficients
      single("ones_72", mkwin(24'h080808, 24'h080808, 1'b0), ModeCustom, {9{8'h01}}, SW'(3),
             '0, 1'b1, 24'h090909);
      single("ones_63", mkwin(24'h070707, 24'h070707, 1'b0), ModeCustom, {9{8'h01}}, SW'(3),
             '0, 1'b1, 24'h080808);
      single("ones_bias", mkwin(24'h080808, 24'h080808, 1'b0), ModeCustom, {9{8'h01}}, SW'(3),
             AW'(-80), 1'b1, 24'h000000);
      single("k5_two", mkwin(24'h555555, 24'h1E140A, 1'b1), ModeCustom, 72'd2 << 32, SW'(1),
             AW'(1), 1'b1, 24'h1F150B);
      single("k1_neg", mkwin(24'h3264FA, 24'h777777, 1'b1), ModeCustom, 72'hFF, '0,
             AW'(200), 1'b1, 24'h966400);

      // Backpressure: 10 identity beats, sink stalled in cycles 4..8
      sent = 0;
      rcv  = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         bus.i_ready = !(cyc >= 4 && cyc <= 8);
         if (sent < 10) begin
            drive(mkwin(24'h777777, bp_ctr(sent), 1'b1), ModeIdentity, '0, '0, '0, sent == 0);
         end else begin
            bus.i_valid = 1'b0;
            bus.i_sof   = 1'b0;
         end
         #1;
         acc = bus.i_valid && bus.o_ready;
         pop = 1'b0;
         if (bus.o_valid) begin
            chk24("bp_pix", bus.o_pix, bp_ctr(rcv));
            chk1("bp_sof", bus.o_sof, rcv == 0);
            if (!bus.i_ready) chk1("bp_ordy_stall", bus.o_ready, 1'b0);
            pop = bus.i_ready;
         end
         tick();
         if (acc) sent++;
         if (pop) rcv++;
      end
      bus.i_ready = 1'b1;
      chki("bp_sent", sent, 10);
      chki("bp_rcv", rcv, 10);
      chk1("bp_empty", bus.o_valid, 1'b0);

      // Frame atomicity: config changes only take effect on an SOF beat
      for (int t = 0; t < 7; t++) begin
         if (t < 4) begin
            drive(at_win, AtMode[t], '0, SW'(AtShift[t]), AW'(AtBias[t]), AtSof[t]);
         end else begin
            bus.i_valid = 1'b0;
            bus.i_sof   = 1'b0;
         end
         tick();
         if (t >= 2 && t <= 5) begin
            chk1("at_vld", bus.o_valid, 1'b1);
            chk24("at_pix", bus.o_pix, AtExp[t-2]);
            chk1("at_sof", bus.o_sof, AtSof[t-2]);
         end
      end
      chk1("at_empty", bus.o_valid, 1'b0);

      // Reset with three beats in flight
      drive(at_win, ModeStrong, '0, '0, '0, 1'b1);
      tick();
      drive(at_win, ModeStrong, '0, '0, '0, 1'b0);
      tick();
      tick();
      chk1("mr_full", bus.o_valid, 1'b1);
      chk24("mr_strong", bus.o_pix, 24'hFFFFFF);
      bus.i_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk1("mr_ordy", bus.o_ready, 1'b0);
      tick();
      chk1("mr_vld", bus.o_valid, 1'b0);
      chk24("mr_pix", bus.o_pix, 24'h0);
      rst = 1'b0;
      tick();
      chk1("mr_ghost1", bus.o_valid, 1'b0);
      tick();
      chk1("mr_ghost2", bus.o_valid, 1'b0);
      single("mr_ident", at_win, ModeSharpen, '0, '0, '0, 1'b0, 24'h323232);
      single("mr_sof", at_win, ModeSharpen, '0, '0, '0, 1'b1, 24'hD2D2D2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
